// File: rtl/alu_pipe_obf.sv
// alu_pipe_obf: key-locked 4-op ALU with serial shift-add constant multiplier.
// valid/ready on both sides; results appear WIDTH edges after accept.
module alu_pipe_obf #(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      KEY_W = 255,
  parameter logic [WIDTH-1:0] CONST = WIDTH'(8'hCE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       op,
  input  logic [KEY_W-1:0] locking_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             out_flag,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH+1:0] wk;
  logic [1:0]       eop;
  logic [WIDTH-1:0] kc;
  logic             accept;
  logic             last;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_flg;

  logic [WIDTH-1:0] in3_q;
  logic [WIDTH-1:0] kc_q;
  logic [WIDTH-1:0] res_q;
  logic             flg_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] out1_q, out2_q;
  logic             flag_q;

  assign wk  = locking_key[WIDTH+1:0];
  assign eop = op ^ wk[1:0];
  assign kc  = CONST ^ wk[WIDTH+1:2];

  generate
    if (KEY_W > WIDTH + 2) begin : g_key_tail
      logic unused_key;
      assign unused_key = ^locking_key[KEY_W-1:WIDTH+2];
    end
  endgenerate

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state_q == MUL) && (cnt_q == CW'(WIDTH - 1));

  assign out1     = out1_q;
  assign out2     = out2_q;
  assign out_flag = flag_q;

  // ALU result for the decoded opcode, captured at accept
  always_comb begin
    sum     = {1'b0, in1} + {1'b0, in2};
    dif     = {1'b0, in1} - {1'b0, in2};
    alu_res = '0;
    alu_flg = 1'b0;
    unique case (eop)
      2'b00: begin
        alu_res = sum[WIDTH-1:0];
        alu_flg = sum[WIDTH];
      end
      2'b01: begin
        alu_res = dif[WIDTH-1:0];
        alu_flg = dif[WIDTH];
      end
      2'b10: begin
        alu_res = in1 ^ in2;
        alu_flg = 1'b0;
      end
      2'b11: begin
        alu_res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        alu_flg = sum[WIDTH];
      end
      default: begin
        alu_res = '0;
        alu_flg = 1'b0;
      end
    endcase
  end

  // one shift-add step of in3 * Kconst
  always_comb begin
    acc_d = acc_q;
    if (kc_q[cnt_q]) begin
      acc_d = acc_q + (in3_q << cnt_q);
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = MUL;
      MUL:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // operand capture and multiplier iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in3_q <= '0;
      kc_q  <= '0;
      res_q <= '0;
      flg_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      in3_q <= in3;
      kc_q  <= kc;
      res_q <= alu_res;
      flg_q <= alu_flg;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == MUL) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // result registers, loaded once per op on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_q <= '0;
      out2_q <= '0;
      flag_q <= 1'b0;
    end else if (last) begin
      out1_q <= res_q;
      out2_q <= acc_d;
      flag_q <= flg_q;
    end
  end

endmodule

// File: tb/tb_alu_pipe_obf.sv
// tb_alu_pipe_obf: scoreboard bench for alu_pipe_obf (WIDTH=8).
// Expected results come from a behavioural model pushed at drive time.
module tb_alu_pipe_obf;

  localparam int W  = 8;
  localparam int KW = 255;

  typedef struct packed {
    logic [7:0] o1;
    logic [7:0] o2;
    logic       f;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1, in2, in3;
  logic [1:0]    op;
  logic [KW-1:0] locking_key;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out1, out2;
  logic          out_flag;
  logic          busy;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_pipe_obf dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .op(op),
    .locking_key(locking_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out1(out1),
    .out2(out2),
    .out_flag(out_flag),
    .busy(busy)
  );

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [1:0] o,
                                 input logic [KW-1:0] k);
    exp_t        r;
    logic [1:0]  eo;
    logic [7:0]  kc;
    logic [8:0]  s;
    logic [15:0] p;
    eo = o ^ k[1:0];
    kc = 8'hCE ^ k[9:2];
    s  = {1'b0, a} + {1'b0, b};
    p  = {8'h00, c} * {8'h00, kc};
    r.f = 1'b0;
    case (eo)
      2'b00: begin r.o1 = s[7:0]; r.f = s[8]; end
      2'b01: begin r.o1 = a - b; r.f = (a < b); end
      2'b10: begin r.o1 = a ^ b; r.f = 1'b0; end
      default: begin r.o1 = s[8] ? 8'hFF : s[7:0]; r.f = s[8]; end
    endcase
    r.o2 = p[7:0];
    return r;
  endfunction

  // drive one op for one accept edge; caller ensures the DUT is idle
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [1:0] o,
                      input logic [KW-1:0] k);
    in1 = a; in2 = b; in3 = c; op = o; locking_key = k;
    in_valid = 1'b1;
    sb.push_back(model(a, b, c, o, k));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // count edges until out_valid, bounded
  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=010", {out_valid, in_ready, busy});
    end
    total++;
    if ({out1, out2, out_flag} !== 17'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%b want=0", out1, out2, out_flag);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    exp_t e;
    int   n;
    send(8'h10, 8'h20, 8'h03, 2'b00, '0);
    total++;
    if ({in_ready, busy} !== 2'b01) begin
      bad++;
      $display("FAIL add_busy got=%b want=01", {in_ready, busy});
    end
    wait_valid(n);
    e = sb.pop_front();
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL add_latency got=%0d want=8", n);
    end
    total++;
    if ({out1, out2, out_flag} !== {e.o1, e.o2, e.f} ||
        {out1, out2, out_flag} !== {8'h30, 8'h6A, 1'b0}) begin
      bad++;
      $display("FAIL add_result got=%h/%h/%b want=30/6a/0",
               out1, out2, out_flag);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL add_handshake got=%b want=010",
               {out_valid, in_ready, busy});
    end
    total++;
    if (out1 !== 8'h30) begin
      bad++;
      $display("FAIL add_hold got=%h want=30", out1);
    end
  endtask

  task automatic test_sub();
    exp_t          e;
    int            n;
    logic [KW-1:0] k;
    k = '0;
    k[0] = 1'b1;
    send(8'h05, 8'h07, 8'h01, 2'b00, k);
    wait_valid(n);
    e = sb.pop_front();
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL sub_latency got=%0d want=8", n);
    end
    total++;
    if ({out1, out2, out_flag} !== {e.o1, e.o2, e.f} ||
        {out1, out2, out_flag} !== {8'hFE, 8'hCE, 1'b1}) begin
      bad++;
      $display("FAIL sub_result got=%h/%h/%b want=fe/ce/1",
               out1, out2, out_flag);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_sat();
    exp_t          e;
    int            n;
    logic [KW-1:0] k;
    k = '0;
    k[9:2] = 8'hCE;
    send(8'hF0, 8'h20, 8'h55, 2'b11, k);
    wait_valid(n);
    e = sb.pop_front();
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL sat_latency got=%0d want=8", n);
    end
    total++;
    if ({out1, out2, out_flag} !== {e.o1, e.o2, e.f} ||
        {out1, out2, out_flag} !== {8'hFF, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL sat_result got=%h/%h/%b want=ff/00/1",
               out1, out2, out_flag);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    send(8'h33, 8'h44, 8'h9A, 2'b10, '0);
    wait_valid(n);
    e = sb.pop_front();
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=8", n);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in1 = 8'($urandom);
      in2 = 8'($urandom);
      in3 = 8'($urandom);
      op  = 2'($urandom);
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, out1, out2, out_flag} !==
          {1'b1, 1'b0, e.o1, e.o2, e.f}) begin
        bad++;
        $display("FAIL bp_stall%0d got=%b%b/%h/%h/%b want=10/%h/%h/%b",
                 i, out_valid, in_ready, out1, out2, out_flag,
                 e.o1, e.o2, e.f);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release got=%b want=01", {out_valid, in_ready});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, out_valid, out1} !== {2'b00, e.o1}) begin
      bad++;
      $display("FAIL bp_no_capture got=%b%b/%h want=00/%h",
               busy, out_valid, out1, e.o1);
    end
  endtask

  task automatic test_key_change();
    exp_t e;
    int   n;
    send(8'h7F, 8'h01, 8'h0B, 2'b11, '0);
    repeat (2) @(posedge clk);
    #1;
    locking_key = '1;
    in3 = 8'hFF;
    wait_valid(n);
    e = sb.pop_front();
    total++;
    if (n !== 6) begin
      bad++;
      $display("FAIL key_latency got=%0d want=6", n);
    end
    total++;
    if ({out1, out2, out_flag} !== {e.o1, e.o2, e.f}) begin
      bad++;
      $display("FAIL key_change got=%h/%h/%b want=%h/%h/%b",
               out1, out2, out_flag, e.o1, e.o2, e.f);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready   = 1'b0;
    locking_key = '0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n;
    send(8'h12, 8'h34, 8'h56, 2'b00, '0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    total++;
    if ({out_valid, busy, out_flag, out1, out2} !== 19'h0 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid got=%b%b%b%b/%h/%h want=0001/00/00",
               out_valid, busy, out_flag, in_ready, out1, out2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'hA5, 8'h0F, 8'h02, 2'b10, '0);
    wait_valid(n);
    e = sb.pop_front();
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL rst_post_latency got=%0d want=8", n);
    end
    total++;
    if ({out1, out2, out_flag} !== {e.o1, e.o2, e.f} ||
        {out1, out2, out_flag} !== {8'hAA, 8'h9C, 1'b0}) begin
      bad++;
      $display("FAIL rst_post_result got=%h/%h/%b want=aa/9c/0",
               out1, out2, out_flag);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t          e;
    int            n;
    logic [7:0]    a, b, c;
    logic [1:0]    o;
    logic [KW-1:0] k;
    k = '0;
    k[9:0] = 10'($urandom);
    send(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), k);
    for (int i = 0; i < 6; i++) begin
      wait_valid(n);
      e = sb.pop_front();
      total++;
      if (n !== 8) begin
        bad++;
        $display("FAIL b2b%0d_latency got=%0d want=8", i, n);
      end
      total++;
      if ({out1, out2, out_flag} !== {e.o1, e.o2, e.f}) begin
        bad++;
        $display("FAIL b2b%0d_result got=%h/%h/%b want=%h/%h/%b",
                 i, out1, out2, out_flag, e.o1, e.o2, e.f);
      end
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      o = 2'($urandom);
      k = '1;
      k[9:0] = 10'($urandom);
      in1 = a; in2 = b; in3 = c; op = o; locking_key = k;
      in_valid  = (i < 5);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
        bad++;
        $display("FAIL b2b%0d_idle got=%b want=010",
                 i, {out_valid, in_ready, busy});
      end
      if (i < 5) begin
        sb.push_back(model(a, b, c, o, k));
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b%0d_accept got=%b want=1", i, busy);
        end
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in1         = '0;
    in2         = '0;
    in3         = '0;
    op          = '0;
    locking_key = '0;
    test_reset();
    test_add();
    test_sub();
    test_sat();
    test_backpressure();
    test_key_change();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
